ssd_scan_sched: RTL and testbench
=================================

// Module: ssd_scan_sched
// PURPOSE
//  Time-multiplexing scheduler for the Nexys-4 eight-digit seven-segment display, whose cathodes are shared
//  by all anodes. It grants the cathode bus to one digit per slot, round-robin.
//  A blanking gap between slots suppresses ghosting. Per-digit blink supports the sindoku cursor cell.
//  Sits in the top level between the game/state-machine datapath (digit nibbles) and the An*/Ca..Cg/Dp pins.
// PARAMETERS
//  N_DIG      8    number of digits scheduled (1..8)
//  SCAN_DIV   17   slot period = 2^SCAN_DIV board_clk cycles (~763 Hz slot rate at 100 MHz)
//  BLANK_CYC  256  blanking cycles at the start of every slot; must satisfy 1 <= BLANK_CYC < 2^SCAN_DIV - 1
//  BLINK_DIV  25   blink phase = bit BLINK_DIV of a free-running counter (~1.5 Hz)
// PORTS
//  board_clk   in   1          100 MHz system clock
//  Reset       in   1          asynchronous, active-high
//  digits_in   in   4*N_DIG    hex nibble per digit; digit i = digits_in[4i+3:4i]
//  dig_en      in   N_DIG      1 = digit i displayed; 0 = its slot runs but anode stays off
//  dp_in       in   N_DIG      1 = decimal point of digit i lit
//  blink_mask  in   N_DIG      1 = digit i blanked during blink-off phase
//  An          out  N_DIG      anodes, active-low, registered
//  Cath        out  8          {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered
//  slot_idx    out  3          index of digit owning the current slot
//  frame_tick  out  1          1-cycle pulse on first cycle of slot 0 (slot_idx wraps N_DIG-1 -> 0)
// BEHAVIOUR
//  Reset: An = all 1, Cath = 8'hFF, slot_idx = 0, frame_tick = 0, slot_cnt = 0, blink counter = 0, state = BLANK.
//  Reset is effective mid-slot: outputs go dark asynchronously. The first slot after release is slot 0 from count 0.
//  slot_cnt: SCAN_DIV-bit up-counter, free-running, wraps 2^SCAN_DIV-1 -> 0. The wrap cycle advances slot_idx
//   (N_DIG-1 -> 0, no skipping of disabled digits: equal slot time keeps brightness uniform).
//  FSM, two states, derived from slot_cnt:
//   BLANK (slot_cnt < BLANK_CYC): An = all 1, Cath = 8'hFF.
//   DRIVE (slot_cnt >= BLANK_CYC): An[slot_idx] = 0 iff dig_en[slot_idx] & ~(blink_ph & blink_mask[slot_idx]); other anodes 1.
//  Snapshot: digits_in/dp_in/dig_en/blink_mask for slot_idx are sampled once, on the edge entering DRIVE,
//   and held for the whole DRIVE window. Input changes mid-slot take effect next slot (no glitching).
//  Outputs are registered from next-state values, so An/Cath change on the same edge slot_cnt changes phase.
//   Drive lasts exactly 2^SCAN_DIV - BLANK_CYC cycles; blank lasts exactly BLANK_CYC cycles.
//  Anode-off cases (disabled or blinked digit): Cath is also forced to 8'hFF.
//  Decode, abcdefg active-low: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111
//   8=0000000 9=0000100 A=0001000 B=1100000 C=0110001 D=1000010 E=0110000 F=0111000; Dp pin = ~dp.
//  blink_ph is sampled only at the snapshot, so a digit never blinks partway through a slot.
//  frame_tick: asserted for the one cycle in which slot_idx == 0 and slot_cnt == 0. Not asserted in the
//   first cycle after reset release; first pulse occurs after a full frame.
//  Never more than one anode low in any cycle, including across the slot boundary. BLANK_CYC >= 1 guarantees this.
// TESTING (bench params: N_DIG=8, SCAN_DIV=4, BLANK_CYC=2, BLINK_DIV=8)
//  Reset pulse mid-DRIVE -> An=8'hFF, Cath=8'hFF immediately; after release, 2 blank cycles, then An=8'hFE.
//  digits_in=32'h76543210, dig_en=8'hFF, dp_in=0 -> slot 0: An=8'hFE, Cath=8'h03 for 14 cycles;
//   slot 5: An=8'hDF, Cath=8'h49; slot_idx sequence 0..7,0; frame_tick every 128 cycles.
//  Change digits_in[3:0] 0->8 in cycle 5 of slot 0 DRIVE -> Cath stays 8'h03 through slot 0; next slot-0 visit Cath=8'h01.
//  dig_en=8'hFB -> slot 2 keeps An=8'hFF, Cath=8'hFF for all 16 cycles; slots 1 and 3 unaffected.
//  blink_mask=8'h01, dp_in=8'h01 -> slot 0 drives An=8'hFE, Cath=8'h02 when blink_ph=0; fully dark when blink_ph=1;
//   toggles every 256 cycles.
//  Every cycle, assertion: popcount(~An) <= 1, and ~An != 0 only when slot_cnt >= 2.

Source files
------------

// File: rtl/ssd_scan_sched.sv
// Round-robin scan scheduler for a shared-cathode seven-segment display.
// Each slot opens with a blanking gap, then drives one digit from a snapshot taken on DRIVE entry.
module ssd_scan_sched #(
    parameter int N_DIG     = 8,
    parameter int SCAN_DIV  = 17,
    parameter int BLANK_CYC = 256,
    parameter int BLINK_DIV = 25
) (
    input  logic                 board_clk,
    input  logic                 Reset,
    input  logic [4*N_DIG-1:0]   digits_in,
    input  logic [N_DIG-1:0]     dig_en,
    input  logic [N_DIG-1:0]     dp_in,
    input  logic [N_DIG-1:0]     blink_mask,
    output logic [N_DIG-1:0]     An,
    output logic [7:0]           Cath,
    output logic [2:0]           slot_idx,
    output logic                 frame_tick
);

    typedef enum logic {BLANK, DRIVE} state_t;

    localparam logic [SCAN_DIV-1:0]  CNT_ONE     = SCAN_DIV'(1);
    localparam logic [SCAN_DIV-1:0]  CNT_MAX     = '1;
    localparam logic [SCAN_DIV-1:0]  BLANK_START = SCAN_DIV'(BLANK_CYC);
    localparam logic [BLINK_DIV:0]   BLINK_ONE   = (BLINK_DIV+1)'(1);
    localparam logic [2:0]           LAST_IDX    = 3'(N_DIG - 1);
    localparam logic [N_DIG-1:0]     AN_ONE      = N_DIG'(1);

    state_t                 state_q, state_d;
    logic [SCAN_DIV-1:0]    slot_cnt_q, slot_cnt_d;
    logic [BLINK_DIV:0]     blink_cnt_q, blink_cnt_d;
    logic [2:0]             slot_idx_q, slot_idx_d;
    logic [N_DIG-1:0]       an_q, an_d;
    logic [7:0]             cath_q, cath_d;
    logic                   frame_tick_q, frame_tick_d;

    logic [3:0]             nib_arr [N_DIG];
    logic                   lit;

    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_nib
        assign nib_arr[gi] = digits_in[4*gi +: 4];
    end

    // Segment pattern {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    always_comb begin
        slot_cnt_d  = slot_cnt_q + CNT_ONE;
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
        slot_idx_d  = slot_idx_q;
        if (slot_cnt_q == CNT_MAX) begin
            slot_idx_d = (slot_idx_q == LAST_IDX) ? 3'd0 : slot_idx_q + 3'd1;
        end

        // Blink phase is read only here, so a digit is either lit or dark for a whole slot.
        lit = dig_en[slot_idx_q] & ~(blink_cnt_q[BLINK_DIV] & blink_mask[slot_idx_q]);

        state_d = state_q;
        an_d    = an_q;
        cath_d  = cath_q;
        case (state_q)
            BLANK: begin
                if (slot_cnt_d == BLANK_START) begin
                    state_d = DRIVE;
                    if (lit) begin
                        an_d   = ~(AN_ONE << slot_idx_q);
                        cath_d = {seg_decode(nib_arr[slot_idx_q]), ~dp_in[slot_idx_q]};
                    end else begin
                        an_d   = '1;
                        cath_d = 8'hFF;
                    end
                end
            end
            default: begin
                if (slot_cnt_d == '0) begin
                    state_d = BLANK;
                    an_d    = '1;
                    cath_d  = 8'hFF;
                end
            end
        endcase

        frame_tick_d = (slot_cnt_d == '0) && (slot_idx_d == 3'd0);
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= BLANK;
            slot_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            slot_idx_q   <= 3'd0;
            an_q         <= '1;
            cath_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_cnt_q   <= slot_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            slot_idx_q   <= slot_idx_d;
            an_q         <= an_d;
            cath_q       <= cath_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign An         = an_q;
    assign Cath       = cath_q;
    assign slot_idx   = slot_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_sched.sv
// Directed bench for ssd_scan_sched with a 16-cycle slot, 2-cycle blank and 256-cycle blink phase.
module tb_ssd_scan_sched;

    logic        board_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic [31:0] digits_in = 32'h76543210;
    logic [7:0]  dig_en    = 8'hFF;
    logic [7:0]  dp_in     = 8'h00;
    logic [7:0]  blink_mask = 8'h00;
    logic [7:0]  An;
    logic [7:0]  Cath;
    logic [2:0]  slot_idx;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ssd_scan_sched #(
        .N_DIG(8), .SCAN_DIV(4), .BLANK_CYC(2), .BLINK_DIV(8)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .digits_in (digits_in),
        .dig_en    (dig_en),
        .dp_in     (dp_in),
        .blink_mask(blink_mask),
        .An        (An),
        .Cath      (Cath),
        .slot_idx  (slot_idx),
        .frame_tick(frame_tick)
    );

    always #5 board_clk = ~board_clk;

    // Cycles since reset release; at a falling edge, slot phase = cyc%16, slot = (cyc/16)%8.
    always @(posedge board_clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // At most one anode low, and none during the two blank cycles of a slot.
    always @(negedge board_clk) begin
        total++;
        if (($countones(~An) > 1) || (An != 8'hFF && !Reset && (cyc % 16) < 2)) begin
            bad++;
            $display("FAIL anode_guard cyc=%0d got An=%h required one-hot-low outside blank", cyc, An);
        end
    end

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic [7:0]  mask;
        int          n;
        logic [7:0]  an;
        logic [7:0]  cath;
    } vec_t;

    vec_t tbl [26];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge board_clk);
        @(negedge board_clk);
        Reset = 1'b0;
    endtask

    task automatic goto(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge board_clk);
            guard++;
        end
        total++;
        if (cyc != n) begin
            bad++;
            $display("FAIL goto_timeout got cyc=%0d required %0d", cyc, n);
        end
    endtask

    initial begin
        tbl[0]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,   1, 8'hFF, 8'hFF};
        tbl[1]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,   2, 8'hFE, 8'h03};
        tbl[2]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,  15, 8'hFE, 8'h03};
        tbl[3]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,  16, 8'hFF, 8'hFF};
        tbl[4]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,  82, 8'hDF, 8'h49};
        tbl[5]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,  40, 8'hFB, 8'h25};
        tbl[6]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,  60, 8'hF7, 8'h0D};
        tbl[7]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00,  70, 8'hEF, 8'h99};
        tbl[8]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00, 100, 8'hBF, 8'h41};
        tbl[9]  = '{32'h76543210, 8'hFF, 8'h00, 8'h00, 120, 8'h7F, 8'h1F};
        tbl[10] = '{32'h76543210, 8'hFB, 8'h00, 8'h00,  37, 8'hFF, 8'hFF};
        tbl[11] = '{32'h76543210, 8'hFB, 8'h00, 8'h00,  19, 8'hFD, 8'h9F};
        tbl[12] = '{32'h76543210, 8'hFB, 8'h00, 8'h00,  56, 8'hF7, 8'h0D};
        tbl[13] = '{32'h76543210, 8'hFF, 8'h08, 8'h00,  60, 8'hF7, 8'h0C};
        tbl[14] = '{32'h76543210, 8'hFF, 8'h01, 8'h01,   2, 8'hFE, 8'h02};
        tbl[15] = '{32'h76543210, 8'hFF, 8'h01, 8'h01, 258, 8'hFF, 8'hFF};
        tbl[16] = '{32'h76543210, 8'hFF, 8'h01, 8'h01, 514, 8'hFE, 8'h02};
        tbl[17] = '{32'h76543210, 8'hFF, 8'h01, 8'h01, 274, 8'hFD, 8'h9F};
        tbl[18] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00,  10, 8'hFE, 8'h01};
        tbl[19] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00,  20, 8'hFD, 8'h09};
        tbl[20] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00,  34, 8'hFB, 8'h11};
        tbl[21] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00,  50, 8'hF7, 8'hC1};
        tbl[22] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00,  66, 8'hEF, 8'h63};
        tbl[23] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00,  82, 8'hDF, 8'h85};
        tbl[24] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00,  98, 8'hBF, 8'h61};
        tbl[25] = '{32'hFEDCBA98, 8'hFF, 8'h00, 8'h00, 116, 8'h7F, 8'h71};

        // Reset state straight after release.
        do_reset();
        chk("reset_an", An, 8'hFF);
        chk("reset_cath", Cath, 8'hFF);
        chk("reset_slot", {5'd0, slot_idx}, 8'd0);
        chk("reset_tick", {7'd0, frame_tick}, 8'd0);

        for (int i = 0; i < 26; i++) begin
            digits_in  = tbl[i].dig;
            dig_en     = tbl[i].en;
            dp_in      = tbl[i].dp;
            blink_mask = tbl[i].mask;
            do_reset();
            goto(tbl[i].n);
            $display("vec %0d cyc=%0d An=%h Cath=%h slot=%0d", i, cyc, An, Cath, slot_idx);
            chk("vec_an", An, tbl[i].an);
            chk("vec_cath", Cath, tbl[i].cath);
            chk("vec_slot", {5'd0, slot_idx}, 8'((tbl[i].n / 16) % 8));
        end

        // Full frame: slot sequence, anode walk and the single frame_tick at cycle 128.
        digits_in = 32'h76543210; dig_en = 8'hFF; dp_in = 8'h00; blink_mask = 8'h00;
        do_reset();
        for (int n = 0; n <= 129; n++) begin
            logic [7:0] exp_an;
            goto(n);
            exp_an = 8'hFF;
            if ((n % 16) >= 2) exp_an[(n / 16) % 8] = 1'b0;
            chk("frame_slot", {5'd0, slot_idx}, 8'((n / 16) % 8));
            chk("frame_tick", {7'd0, frame_tick}, {7'd0, n == 128});
            chk("frame_an", An, exp_an);
        end
        $display("frame walk done cyc=%0d", cyc);

        // Mid-slot input change is ignored until the next visit to slot 0.
        do_reset();
        goto(7);
        digits_in[3:0] = 4'h8;
        for (int n = 8; n <= 15; n++) begin
            goto(n);
            chk("midslot_hold", Cath, 8'h03);
        end
        goto(130);
        chk("midslot_next", Cath, 8'h01);
        $display("midslot change cyc=%0d Cath=%h", cyc, Cath);

        // Asynchronous reset in the middle of a DRIVE window.
        digits_in = 32'h76543210;
        do_reset();
        goto(40);
        chk("pre_reset_an", An, 8'hFB);
        Reset = 1'b1;
        #1;
        chk("async_an", An, 8'hFF);
        chk("async_cath", Cath, 8'hFF);
        repeat (2) @(posedge board_clk);
        @(negedge board_clk);
        Reset = 1'b0;
        goto(1);
        chk("post_reset_blank", An, 8'hFF);
        goto(2);
        chk("post_reset_an", An, 8'hFE);
        chk("post_reset_cath", Cath, 8'h03);
        $display("reset mid-drive recovery cyc=%0d An=%h", cyc, An);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
